// File: rtl/gates_bist_pkg.sv
// Shared types and constants for the NAND/NOR gate-block self-test checker.
// Golden tables are indexed by the vector index {a,b}.
package gates_bist_pkg;

  localparam int unsigned IDX_W = 2;

  // Bit i holds the expected gate output for vector i = {a,b}
  localparam logic [3:0] NAND_GOLD = 4'b0111;
  localparam logic [3:0] NOR_GOLD  = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/gates_bist_cmp.sv
// Golden comparison and saturating mismatch counter for the gate-block checker.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   idx          - vector index {a,b} currently applied to the gate block
//   nand_in      - sampled gate-block NAND output
//   nor_in       - sampled gate-block NOR output
//   clr          - synchronous clear of err_cnt (new run)
//   en           - count enable (asserted on a mismatching sample)
//   mismatch_c   - combinational: either output differs from golden
//   err_cnt      - saturating mismatch count
module gates_bist_cmp
  import gates_bist_pkg::*;
#(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic             nand_in,
  input  logic             nor_in,
  input  logic             clr,
  input  logic             en,
  output logic             mismatch_c,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic exp_nand_c;
  logic exp_nor_c;

  // Golden lookup; a fault on either output counts once for the vector
  always_comb begin
    exp_nand_c = NAND_GOLD[idx];
    exp_nor_c  = NOR_GOLD[idx];
    mismatch_c = (nand_in != exp_nand_c) || (nor_in != exp_nor_c);
  end

  // Saturating counter: holds at all-ones, never wraps
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_cnt <= '0;
    end else if (en && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: rtl/gates_bist_checker.sv
// Self-test engine for the two-input NAND/NOR gate block: sweeps all four
// {a,b} vectors PASSES times, waits SETTLE_CYCLES after each drive, samples
// the gate outputs, counts mismatches and reports pass/fail.
// Optional: define GATES_BIST_STOP_ON_FAIL_EN to end the run at the first
// mismatching sample.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - one-cycle run request (ignored while busy)
//   a_out, b_out    - drives to gate block inputs
//   nand_in, nor_in - gate block outputs
//   busy            - run in progress
//   done            - run complete, sticky until next start or rst
//   pass            - valid with done: no mismatches seen
//   err_cnt         - saturating mismatch count
//   first_fail_idx  - {a,b} of the first mismatching vector
//   first_fail_vld  - first_fail_idx valid
module gates_bist_checker
  import gates_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             nand_in,
  input  logic             nor_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       first_fail_idx,
  output logic             first_fail_vld
);

  localparam int unsigned SET_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  state_t              state, state_d;
  logic [IDX_W-1:0]    idx, idx_d;
  logic [PASS_W-1:0]   pcnt, pcnt_d;
  logic [SET_W-1:0]    scnt, scnt_d;
  logic                a_d, b_d, busy_d, done_d, pass_d, ffv_d;
  logic [1:0]          ffi_d;
  logic                clr_c, en_c, mismatch_c;
  logic                last_c, go_done_c;

  gates_bist_cmp #(
    .ERR_W (ERR_W)
  ) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .nand_in    (nand_in),
    .nor_in     (nor_in),
    .clr        (clr_c),
    .en         (en_c),
    .mismatch_c (mismatch_c),
    .err_cnt    (err_cnt)
  );

  // Final vector of the final sweep
  assign last_c = (idx == IDX_LAST) && (pcnt == PASS_W'(PASSES - 1));

`ifdef GATES_BIST_STOP_ON_FAIL_EN
  assign go_done_c = last_c || mismatch_c;
`else
  assign go_done_c = last_c;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    idx_d   = idx;
    pcnt_d  = pcnt;
    scnt_d  = scnt;
    a_d     = a_out;
    b_d     = b_out;
    busy_d  = busy;
    done_d  = done;
    pass_d  = pass;
    ffi_d   = first_fail_idx;
    ffv_d   = first_fail_vld;
    clr_c   = 1'b0;
    en_c    = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          clr_c   = 1'b1;
          ffv_d   = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          idx_d   = '0;
          pcnt_d  = '0;
          busy_d  = 1'b1;
        end
      end

      ST_DRIVE: begin
        a_d     = idx[1];
        b_d     = idx[0];
        scnt_d  = SET_W'(SETTLE_CYCLES);
        state_d = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_SAMPLE;
      end

      ST_SETTLE: begin
        scnt_d = scnt - SET_W'(1);
        if (scnt <= SET_W'(1)) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        en_c = mismatch_c;
        if (mismatch_c && !first_fail_vld) begin
          ffi_d = idx;
          ffv_d = 1'b1;
        end
        if (go_done_c) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // err_cnt is zero exactly when no sample has mismatched
          pass_d  = !(mismatch_c || first_fail_vld);
        end else begin
          state_d = ST_DRIVE;
          idx_d   = idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
            pcnt_d = pcnt + PASS_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      idx            <= '0;
      pcnt           <= '0;
      scnt           <= '0;
      a_out          <= 1'b0;
      b_out          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      pcnt           <= pcnt_d;
      scnt           <= scnt_d;
      a_out          <= a_d;
      b_out          <= b_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      first_fail_idx <= ffi_d;
      first_fail_vld <= ffv_d;
    end
  end

endmodule

// File: tb/tb_gates_bist_checker.sv
// Scoreboard bench for gates_bist_checker: a behavioural gate block with
// selectable faults feeds the checker; each run pushes its expected result,
// and a monitor pops and compares when done rises.
module tb_gates_bist_checker;

  localparam int unsigned S    = 2;
  localparam int unsigned P    = 2;
  localparam int unsigned EW   = 3;
  localparam int          FULL = 32;  // P * 4 vectors * (S + 2)

`ifdef GATES_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          a_out, b_out;
  logic          nand_in, nor_in;
  logic          busy, done, pass;
  logic [EW-1:0] err_cnt;
  logic [1:0]    first_fail_idx;
  logic          first_fail_vld;

  int fault = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int busy_cyc;
    int err;
    int pass;
    int ffv;
    int ffi;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   bcnt = 0;
  bit   prev_done = 1'b0;

  always #5 clk = ~clk;

  gates_bist_checker #(
    .SETTLE_CYCLES (S),
    .PASSES        (P),
    .ERR_W         (EW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .a_out          (a_out),
    .b_out          (b_out),
    .nand_in        (nand_in),
    .nor_in         (nor_in),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_vld (first_fail_vld)
  );

  // Gate block model with injectable faults
  always_comb begin
    case (fault)
      1:       begin nand_in = 1'b1;             nor_in = ~(a_out | b_out); end
      2:       begin nand_in = ~(a_out & b_out); nor_in = a_out | b_out;    end
      3:       begin nand_in = a_out & b_out;    nor_in = a_out | b_out;    end
      4:       begin nand_in = 1'b0;             nor_in = ~(a_out | b_out); end
      default: begin nand_in = ~(a_out & b_out); nor_in = ~(a_out | b_out); end
    endcase
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: sweep order at each sample cycle, result on done rising edge
  always @(negedge clk) begin
    if (rst) begin
      bcnt      = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) begin
        bcnt++;
        if ((bcnt % (S + 2)) == 0)
          check("ab_vector", int'({a_out, b_out}), ((bcnt / (S + 2)) - 1) % 4);
      end
      if (done && !prev_done) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1, expected no pending run");
        end else begin
          e = q.pop_front();
          check("busy_cycles", bcnt, e.busy_cyc);
          check("busy_at_done", int'(busy), 0);
          check("err_cnt", int'(err_cnt), e.err);
          check("pass", int'(pass), e.pass);
          check("first_fail_vld", int'(first_fail_vld), e.ffv);
          if (e.ffv != 0) check("first_fail_idx", int'(first_fail_idx), e.ffi);
        end
        bcnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic run(input int f, input int eb, input int ee, input int ep,
                     input int efv, input int efi, input bit repulse);
    int t;
    exp_t x;
    fault = f;
    x.busy_cyc = eb; x.err = ee; x.pass = ep; x.ffv = efv; x.ffi = efi;
    q.push_back(x);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (repulse) begin
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, expected done=1", t);
      q.delete();
    end else begin
      repeat (3) @(negedge clk);
      check("done_sticky", int'(done), 1);
      check("busy_idle", int'(busy), 0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, int'(a_out), 0);
    check({tag, "_b"}, int'(b_out), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err"}, int'(err_cnt), 0);
    check({tag, "_ffv"}, int'(first_fail_vld), 0);
    check({tag, "_ffi"}, int'(first_fail_idx), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Clean sweep
    run(0, FULL, 0, 1, 0, 0, 1'b0);
    // nand stuck at 1: only vector 3 fails, once per sweep
    run(1, STOP ? 16 : FULL, STOP ? 1 : 2, 0, 1, 3, 1'b0);
    // nor inverted: all 8 samples fail, counter saturates at 7
    run(2, STOP ? 4 : FULL, STOP ? 1 : 7, 0, 1, 0, 1'b0);
    // both outputs inverted: saturation, no wrap
    run(3, STOP ? 4 : FULL, STOP ? 1 : 7, 0, 1, 0, 1'b0);
    // nand stuck at 0: vectors 0..2 fail per sweep
    run(4, STOP ? 4 : FULL, STOP ? 1 : 6, 0, 1, 0, 1'b0);
    // Clean run after failures clears prior result
    run(0, FULL, 0, 1, 0, 0, 1'b0);

    // Reset during SETTLE of vector 2 (busy cycle 10)
    fault = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;

    // Fresh run with start re-pulsed while busy
    run(0, FULL, 0, 1, 0, 0, 1'b1);

    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
